// File: rtl/binary_char_printer.sv
// binary_char_printer
//   Buffers received bytes in a small FIFO. Each byte is printed on the UART
//   transmit side as eight ASCII digits ('0' = 8'h30, '1' = 8'h31), optionally
//   followed by CR LF.
//
//   Handshakes: new_rx_data is a one-cycle strobe that qualifies rx_data.
//   new_tx_data is a registered one-cycle strobe that qualifies tx_data. A
//   strobe is only issued when tx_busy is low. Every strobe is followed by one
//   gap cycle, because the UART raises busy one cycle late, so two strobes are
//   never adjacent.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   rx_data      in   [7:0] received byte
//   new_rx_data  in   rx_data valid strobe
//   tx_busy      in   UART transmitter busy
//   tx_data      out  [7:0] character to send (registered)
//   new_tx_data  out  tx_data valid strobe (registered)
//   overflow     out  one-cycle pulse: incoming byte dropped, FIFO full
//   idle         out  FIFO empty and FSM in IDLE
module binary_char_printer #(
  parameter int FIFO_DEPTH     = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter bit APPEND_NEWLINE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       new_rx_data,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       new_tx_data,
  output logic       overflow,
  output logic       idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EMIT = 3'd1,
    GAP  = 3'd2,
    CR   = 3'd3,
    GAP2 = 3'd4,
    LF   = 3'd5,
    GAP3 = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              new_tx_q, new_tx_d;
  logic              overflow_q, overflow_d;

  logic fifo_full, fifo_empty, pop, wr_en, digit;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a write on full is still accepted.
  assign wr_en      = new_rx_data && (!fifo_full || pop);
  assign digit      = MSB_FIRST ? shift_q[7] : shift_q[0];

  // FIFO storage and pointers
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 1'b1;
    end
    overflow_d = new_rx_data && !wr_en;
  end

  // Print sequencer
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_data_d = tx_data_q;
    new_tx_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = 4'd0;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (!tx_busy) begin
          tx_data_d = {7'b0011000, digit};
          new_tx_d  = 1'b1;
          shift_d   = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (bit_cnt_q < 4'd8) begin
          state_d = EMIT;
        end else if (APPEND_NEWLINE) begin
          state_d = CR;
        end else begin
          state_d = IDLE;
        end
      end
      CR: begin
        if (!tx_busy) begin
          tx_data_d = 8'h0D;
          new_tx_d  = 1'b1;
          state_d   = GAP2;
        end
      end
      GAP2: state_d = LF;
      LF: begin
        if (!tx_busy) begin
          tx_data_d = 8'h0A;
          new_tx_d  = 1'b1;
          state_d   = GAP3;
        end
      end
      GAP3:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 4'd0;
      tx_data_q  <= 8'h00;
      new_tx_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_data_q  <= tx_data_d;
      new_tx_q   <= new_tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign overflow    = overflow_q;
  assign idle        = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_binary_char_printer.sv
module tb_binary_char_printer;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       new_rx_a, new_rx_b;
  logic       tx_busy;
  logic [7:0] tx_data_a, tx_data_b;
  logic       new_tx_a, new_tx_b;
  logic       overflow_a, overflow_b;
  logic       idle_a, idle_b;

  int n_tests = 0;
  int n_fail  = 0;
  int strobes_a = 0;
  int ovf_cnt_a = 0;
  int ovf_cnt_b = 0;
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];

  // Default build: MSB first, CR LF appended.
  binary_char_printer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1), .APPEND_NEWLINE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_a),
    .tx_busy(tx_busy), .tx_data(tx_data_a), .new_tx_data(new_tx_a),
    .overflow(overflow_a), .idle(idle_a));

  // LSB first, digits only.
  binary_char_printer #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0), .APPEND_NEWLINE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .new_rx_data(new_rx_b),
    .tx_busy(tx_busy), .tx_data(tx_data_b), .new_tx_data(new_tx_b),
    .overflow(overflow_b), .idle(idle_b));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] c);
    exp_a_q.push_back(c);
  endtask

  // Drivers
  task automatic send_a(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    new_rx_a = 1'b1;
    @(negedge clk);
    new_rx_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    new_rx_b = 1'b1;
    @(negedge clk);
    new_rx_b = 1'b0;
  endtask

  task automatic drain_a(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_a_q.size() == 0 && idle_a) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drain_a"}, (exp_a_q.size() == 0 && idle_a), 1);
  endtask

  task automatic drain_b(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_b_q.size() == 0 && idle_b) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drain_b"}, (exp_b_q.size() == 0 && idle_b), 1);
  endtask

  // Scoreboard monitors: every strobe is popped against the expected queue
  // and checked for back-to-back strobes.
  initial begin : mon_a
    logic prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (overflow_a) ovf_cnt_a++;
        if (new_tx_a) begin
          strobes_a++;
          n_tests++;
          if (prev) begin
            n_fail++;
            $display("FAIL a_spacing: strobe in consecutive cycles, got %0h", tx_data_a);
          end else if (exp_a_q.size() == 0) begin
            n_fail++;
            $display("FAIL a_unexpected: got %0h expected no strobe", tx_data_a);
          end else begin
            e = exp_a_q.pop_front();
            if (tx_data_a !== e) begin
              n_fail++;
              $display("FAIL a_char: got %0h expected %0h", tx_data_a, e);
            end
          end
        end
        prev = new_tx_a;
      end
    end
  end

  initial begin : mon_b
    logic prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (overflow_b) ovf_cnt_b++;
        if (new_tx_b) begin
          n_tests++;
          if (prev) begin
            n_fail++;
            $display("FAIL b_spacing: strobe in consecutive cycles, got %0h", tx_data_b);
          end else if (exp_b_q.size() == 0) begin
            n_fail++;
            $display("FAIL b_unexpected: got %0h expected no strobe", tx_data_b);
          end else begin
            e = exp_b_q.pop_front();
            if (tx_data_b !== e) begin
              n_fail++;
              $display("FAIL b_char: got %0h expected %0h", tx_data_b, e);
            end
          end
        end
        prev = new_tx_b;
      end
    end
  end

  // Hand-computed character tables (MSB first, CR LF appended).
  logic [7:0] seq_01 [10] = '{8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h31,8'h0D,8'h0A};
  logic [7:0] seq_02 [10] = '{8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h31,8'h30,8'h0D,8'h0A};
  logic [7:0] seq_03 [10] = '{8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h31,8'h31,8'h0D,8'h0A};
  logic [7:0] seq_04 [10] = '{8'h30,8'h30,8'h30,8'h30,8'h30,8'h31,8'h30,8'h30,8'h0D,8'h0A};
  logic [7:0] seq_05 [10] = '{8'h30,8'h30,8'h30,8'h30,8'h30,8'h31,8'h30,8'h31,8'h0D,8'h0A};
  logic [7:0] seq_a5 [10] = '{8'h31,8'h30,8'h31,8'h30,8'h30,8'h31,8'h30,8'h31,8'h0D,8'h0A};
  logic [7:0] seq_80 [10] = '{8'h31,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h0D,8'h0A};
  logic [7:0] seq_b01 [8] = '{8'h31,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30};

  initial begin : main
    int cnt;
    int target;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    new_rx_a = 1'b0;
    new_rx_b = 1'b0;
    tx_busy  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_data", tx_data_a, 8'h00);
    check("rst_new_tx", new_tx_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_idle", idle_a, 1);
    check("rst_idle_b", idle_b, 1);
    rst_n = 1'b1;

    // 1: 8'hA5, MSB first with CR LF
    foreach (seq_a5[i]) push_a(seq_a5[i]);
    send_a(8'hA5);
    check("t1_idle_low", idle_a, 0);
    drain_a("t1", 200);

    // 2: LSB first, no newline, 8'h01
    foreach (seq_b01[i]) exp_b_q.push_back(seq_b01[i]);
    send_b(8'h01);
    drain_b("t2", 200);

    // 3: 8'hFF held off by tx_busy for 50 cycles
    tx_busy = 1'b1;
    for (int i = 0; i < 8; i++) push_a(8'h31);
    push_a(8'h0D);
    push_a(8'h0A);
    send_a(8'hFF);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (new_tx_a) cnt++;
    end
    check("t3_no_strobe_busy", cnt, 0);
    check("t3_not_idle", idle_a, 0);
    tx_busy = 1'b0;
    drain_a("t3", 200);

    // 4: six back-to-back bytes into a depth-4 FIFO while busy
    ovf_cnt_a = 0;
    tx_busy = 1'b1;
    foreach (seq_01[i]) push_a(seq_01[i]);
    foreach (seq_02[i]) push_a(seq_02[i]);
    foreach (seq_03[i]) push_a(seq_03[i]);
    foreach (seq_04[i]) push_a(seq_04[i]);
    foreach (seq_05[i]) push_a(seq_05[i]);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      rx_data  = 8'(i);
      new_rx_a = 1'b1;
    end
    @(negedge clk);
    new_rx_a = 1'b0;
    #1;
    check("t4_overflow_pulse", overflow_a, 1);
    @(negedge clk);
    #1;
    check("t4_overflow_one_cycle", overflow_a, 0);
    repeat (5) @(negedge clk);
    tx_busy = 1'b0;
    drain_a("t4", 1000);
    check("t4_overflow_count", ovf_cnt_a, 1);

    // 5: reset after third strobe of 8'h0F, then 8'h80
    push_a(8'h30);
    push_a(8'h30);
    push_a(8'h30);
    target = strobes_a + 3;
    send_a(8'h0F);
    cnt = 0;
    while (strobes_a < target && cnt < 200) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("t5_three_strobes", strobes_a, target);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx_data", tx_data_a, 8'h00);
    check("t5_rst_new_tx", new_tx_a, 0);
    check("t5_rst_overflow", overflow_a, 0);
    check("t5_rst_idle", idle_a, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    target = strobes_a;
    repeat (40) @(negedge clk);
    #1;
    check("t5_no_strobe_after_rst", strobes_a, target);
    foreach (seq_80[i]) push_a(seq_80[i]);
    send_a(8'h80);
    drain_a("t5", 200);

    check("overflow_b_never", ovf_cnt_b, 0);
    check("queue_b_empty", exp_b_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
